// File: rtl/object_rasterizer.sv
// Back-buffer writer: optionally clears the frame, then fills each valid object's clipped rectangle.
// Optional clear phase is compiled in when OBJECT_RASTERIZER_CLEAR_EN is defined.
`timescale 1ns/1ps

package object_rasterizer_pkg;
  localparam int unsigned PIX_W   = 12;
  localparam int unsigned COORD_W = 10;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    pixel_t             color;
  } obj_t;
endpackage

module object_rasterizer
  import object_rasterizer_pkg::*;
#(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned MAX_OBJECTS = 64,
  parameter pixel_t      BG_COLOR    = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           next_frame,
  output logic [$clog2(MAX_OBJECTS)-1:0] obj_addr,
  input  logic [$bits(obj_t)-1:0]        obj_data,
  output logic [COORD_W-1:0]             address_x,
  output logic [COORD_W-1:0]             address_y,
  output pixel_t                         write_data,
  output logic                           write_enable,
  output logic                           object_buffer_read_end,
  output logic                           frame_overrun
);

  localparam int unsigned OA_W  = $clog2(MAX_OBJECTS);
  localparam int unsigned SUM_W = COORD_W + 1;

`ifdef OBJECT_RASTERIZER_CLEAR_EN
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, LATCH, DRAW, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, DRAW, DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [OA_W-1:0]    obj_addr_q, obj_addr_d;
  logic [COORD_W-1:0] address_x_q, address_x_d;
  logic [COORD_W-1:0] address_y_q, address_y_d;
  pixel_t             write_data_q, write_data_d;
  logic               write_enable_q, write_enable_d;
  logic               read_end_q, read_end_d;
  logic               frame_overrun_q, frame_overrun_d;
  logic [COORD_W-1:0] x0_q, x0_d;
  logic [COORD_W-1:0] xe_q, xe_d;
  logic [COORD_W-1:0] ye_q, ye_d;

  obj_t             obj;
  logic [SUM_W-1:0] x_sum;
  logic [SUM_W-1:0] y_sum;
  logic             skip;
  logic             advance;
  logic             last_obj;

  assign obj = obj_t'(obj_data);

  // Next-state and registered-output logic; the address registers double as scan counters.
  always_comb begin
    state_d         = state_q;
    obj_addr_d      = obj_addr_q;
    address_x_d     = address_x_q;
    address_y_d     = address_y_q;
    write_data_d    = write_data_q;
    write_enable_d  = 1'b0;
    read_end_d      = read_end_q;
    frame_overrun_d = 1'b0;
    x0_d            = x0_q;
    xe_d            = xe_q;
    ye_d            = ye_q;
    advance         = 1'b0;

    x_sum    = SUM_W'(obj.x) + SUM_W'(obj.w) - SUM_W'(1);
    y_sum    = SUM_W'(obj.y) + SUM_W'(obj.h) - SUM_W'(1);
    skip     = (obj.w == '0) || (obj.h == '0) ||
               (32'(obj.x) >= H_RES) || (32'(obj.y) >= V_RES);
    last_obj = (obj_addr_q == OA_W'(MAX_OBJECTS - 1));

    if (next_frame && (state_q != IDLE) && (state_q != DONE)) begin
      frame_overrun_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (next_frame) begin
          read_end_d   = 1'b0;
          obj_addr_d   = '0;
          write_data_d = BG_COLOR;
`ifdef OBJECT_RASTERIZER_CLEAR_EN
          state_d        = CLEAR;
          write_enable_d = 1'b1;
          address_x_d    = '0;
          address_y_d    = '0;
`else
          state_d = FETCH;
`endif
        end
      end
`ifdef OBJECT_RASTERIZER_CLEAR_EN
      CLEAR: begin
        if (address_x_q == COORD_W'(H_RES - 1)) begin
          if (address_y_q == COORD_W'(V_RES - 1)) begin
            state_d = FETCH;
          end else begin
            address_x_d    = '0;
            address_y_d    = address_y_q + COORD_W'(1);
            write_enable_d = 1'b1;
          end
        end else begin
          address_x_d    = address_x_q + COORD_W'(1);
          write_enable_d = 1'b1;
        end
      end
`endif
      FETCH: state_d = LATCH;
      LATCH: begin
        if (!obj.valid) begin
          state_d    = DONE;
          read_end_d = 1'b1;
        end else if (skip) begin
          advance = 1'b1;
        end else begin
          // Clip on the 11-bit sums so a rectangle near the right edge never wraps.
          x0_d           = obj.x;
          xe_d           = (x_sum > SUM_W'(H_RES - 1)) ? COORD_W'(H_RES - 1) : x_sum[COORD_W-1:0];
          ye_d           = (y_sum > SUM_W'(V_RES - 1)) ? COORD_W'(V_RES - 1) : y_sum[COORD_W-1:0];
          address_x_d    = obj.x;
          address_y_d    = obj.y;
          write_data_d   = obj.color;
          write_enable_d = 1'b1;
          state_d        = DRAW;
        end
      end
      DRAW: begin
        if (address_x_q == xe_q) begin
          if (address_y_q == ye_q) begin
            advance = 1'b1;
          end else begin
            address_x_d    = x0_q;
            address_y_d    = address_y_q + COORD_W'(1);
            write_enable_d = 1'b1;
          end
        end else begin
          address_x_d    = address_x_q + COORD_W'(1);
          write_enable_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (last_obj) begin
        state_d    = DONE;
        read_end_d = 1'b1;
      end else begin
        obj_addr_d = obj_addr_q + OA_W'(1);
        state_d    = FETCH;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      obj_addr_q      <= '0;
      address_x_q     <= '0;
      address_y_q     <= '0;
      write_data_q    <= '0;
      write_enable_q  <= 1'b0;
      read_end_q      <= 1'b0;
      frame_overrun_q <= 1'b0;
      x0_q            <= '0;
      xe_q            <= '0;
      ye_q            <= '0;
    end else begin
      state_q         <= state_d;
      obj_addr_q      <= obj_addr_d;
      address_x_q     <= address_x_d;
      address_y_q     <= address_y_d;
      write_data_q    <= write_data_d;
      write_enable_q  <= write_enable_d;
      read_end_q      <= read_end_d;
      frame_overrun_q <= frame_overrun_d;
      x0_q            <= x0_d;
      xe_q            <= xe_d;
      ye_q            <= ye_d;
    end
  end

  assign obj_addr               = obj_addr_q;
  assign address_x              = address_x_q;
  assign address_y              = address_y_q;
  assign write_data             = write_data_q;
  assign write_enable           = write_enable_q;
  assign object_buffer_read_end = read_end_q;
  assign frame_overrun          = frame_overrun_q;

endmodule

// File: tb/tb_object_rasterizer.sv
// Bench for object_rasterizer: directed and random object lists against a write-list reference model.
`timescale 1ns/1ps

module tb_object_rasterizer;
  import object_rasterizer_pkg::*;

  localparam int unsigned H    = 8;
  localparam int unsigned V    = 4;
  localparam int unsigned NOBJ = 4;
  localparam pixel_t      BG   = pixel_t'(5);

  logic                    clock;
  logic                    reset;
  logic                    next_frame;
  logic [1:0]              obj_addr;
  logic [$bits(obj_t)-1:0] obj_data;
  logic [COORD_W-1:0]      address_x;
  logic [COORD_W-1:0]      address_y;
  pixel_t                  write_data;
  logic                    write_enable;
  logic                    object_buffer_read_end;
  logic                    frame_overrun;

  obj_t        mem [NOBJ];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  object_rasterizer #(
    .H_RES(H), .V_RES(V), .MAX_OBJECTS(NOBJ), .BG_COLOR(BG)
  ) dut (
    .clock(clock), .reset(reset), .next_frame(next_frame),
    .obj_addr(obj_addr), .obj_data(obj_data),
    .address_x(address_x), .address_y(address_y),
    .write_data(write_data), .write_enable(write_enable),
    .object_buffer_read_end(object_buffer_read_end),
    .frame_overrun(frame_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Object buffer with one-cycle read latency.
  always @(posedge clock) obj_data <= mem[obj_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic obj_t mk(input int v, input int x, input int y, input int w, input int h, input int c);
    obj_t o;
    o.valid = 1'(v);
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.w     = 10'(w);
    o.h     = 10'(h);
    o.color = pixel_t'(c);
    return o;
  endfunction

  // Reference: ordered list of expected writes, cycle of read_end, cycle of first write.
  task automatic model(output int ncyc, output int first);
    int xe, ye;
    exp_q.delete();
    ncyc  = 0;
    first = 0;
`ifdef OBJECT_RASTERIZER_CLEAR_EN
    first = 1;
    for (int yy = 0; yy < int'(V); yy++)
      for (int xx = 0; xx < int'(H); xx++)
        exp_q.push_back({10'(xx), 10'(yy), BG});
    ncyc = int'(H * V);
`endif
    for (int i = 0; i < int'(NOBJ); i++) begin
      ncyc += 2;
      if (!mem[i].valid) break;
      if (mem[i].w == 0 || mem[i].h == 0 || int'(mem[i].x) >= int'(H) || int'(mem[i].y) >= int'(V)) continue;
      xe = int'(mem[i].x) + int'(mem[i].w) - 1;
      ye = int'(mem[i].y) + int'(mem[i].h) - 1;
      if (xe > int'(H) - 1) xe = int'(H) - 1;
      if (ye > int'(V) - 1) ye = int'(V) - 1;
      if (first == 0) first = ncyc + 1;
      for (int yy = int'(mem[i].y); yy <= ye; yy++)
        for (int xx = int'(mem[i].x); xx <= xe; xx++) begin
          exp_q.push_back({10'(xx), 10'(yy), mem[i].color});
          ncyc++;
        end
    end
    ncyc += 1;
  endtask

  // Run one frame; ovr_req > 0 pulses next_frame at that cycle, < 0 picks randomly.
  task automatic run_frame(input string tag, input int ovr_req);
    int exp_cyc, exp_first, cyc, first_we, n_ovr, ovr_at;
    logic [31:0] last;
    model(exp_cyc, exp_first);
    ovr_at = ovr_req;
    if (ovr_req < 0)
      ovr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, exp_cyc - 1)) : 0;
    got_q.delete();
    @(negedge clock); next_frame = 1'b1;
    @(negedge clock); next_frame = 1'b0;
    cyc = 1; first_we = 0; n_ovr = 0;
    forever begin
      if (write_enable) begin
        got_q.push_back({address_x, address_y, write_data});
        if (first_we == 0) first_we = cyc;
      end
      if (frame_overrun) n_ovr++;
      if (object_buffer_read_end || cyc >= 2000) break;
      next_frame = (cyc == ovr_at);
      @(negedge clock);
      cyc++;
    end
    next_frame = 1'b0;
    check({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " first_write"}, 32'(first_we), 32'(exp_first));
    check({tag, " write_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s write%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, " overrun"}, 32'(n_ovr), (ovr_at > 0) ? 32'd1 : 32'd0);
    repeat (3) begin
      @(negedge clock);
      check({tag, " hold_read_end"}, 32'(object_buffer_read_end), 32'd1);
      check({tag, " hold_we"}, 32'(write_enable), 32'd0);
      if (exp_q.size() > 0) begin
        last = exp_q[exp_q.size() - 1];
        check({tag, " hold_addr"}, 32'({address_x, address_y}), 32'(last[31:12]));
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    next_frame = 1'b0;
    for (int i = 0; i < int'(NOBJ); i++) mem[i] = mk(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    check("rst we", 32'(write_enable), 32'd0);
    check("rst read_end", 32'(object_buffer_read_end), 32'd0);
    check("rst overrun", 32'(frame_overrun), 32'd0);
    check("rst obj_addr", 32'(obj_addr), 32'd0);
    check("rst addr", 32'({address_x, address_y}), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    run_frame("empty", 0);
`ifdef OBJECT_RASTERIZER_CLEAR_EN
    check("empty literal", 32'(got_q.size()), 32'd32);
`else
    check("empty literal", 32'(got_q.size()), 32'd0);
`endif

    mem[0] = mk(1, 2, 1, 3, 2, 9);
    mem[1] = mk(0, 0, 0, 0, 0, 0);
    run_frame("rect", 0);
`ifdef OBJECT_RASTERIZER_CLEAR_EN
    check("rect literal", 32'(got_q.size()), 32'd38);
    run_frame("rect_ovr", 36);
`else
    check("rect literal", 32'(got_q.size()), 32'd6);
    run_frame("rect_ovr", 4);
`endif

    mem[0] = mk(1, 6, 3, 5, 5, 7);
    run_frame("clip", 0);
    mem[0] = mk(1, 1020, 0, 10, 1, 4);
    run_frame("nowrap", 0);

    mem[0] = mk(1, 0, 0, 0, 2, 1);
    mem[1] = mk(1, 8, 0, 2, 2, 2);
    mem[2] = mk(1, 0, 0, 1, 1, 3);
    mem[3] = mk(1, 1, 1, 2, 0, 6);
    run_frame("skips", 0);

    // Asynchronous reset in the middle of a frame.
    mem[0] = mk(1, 0, 0, 8, 4, 10);
    mem[1] = mk(0, 0, 0, 0, 0, 0);
    @(negedge clock); next_frame = 1'b1;
    @(negedge clock); next_frame = 1'b0;
    repeat (4) @(negedge clock);
    check("midrst we_before", 32'(write_enable), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst we_async", 32'(write_enable), 32'd0);
    check("midrst read_end", 32'(object_buffer_read_end), 32'd0);
    @(negedge clock); reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("midrst idle_we", 32'(write_enable), 32'd0);
      check("midrst idle_read_end", 32'(object_buffer_read_end), 32'd0);
    end
    run_frame("after_rst", 0);

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < int'(NOBJ); i++) begin
        mem[i] = mk(($urandom_range(0, 7) != 0) ? 1 : 0,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(1018, 1023)) : int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 5)),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4095)));
      end
      run_frame($sformatf("rand%0d", f), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
